// File: rtl/matmul_requant_out.sv
// rtl/matmul_requant_out.sv - requantizing output stage with row FIFO (optional MATMUL_REQUANT_RELU_EN)
module matmul_requant_out #(
   parameter int MAC_NUM    = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int OUT_WIDTH  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int ROWS       = 8
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           clear_i,
   input  logic [4:0]                     shift_i,
   input  logic                           done_i,
   input  logic [MAC_NUM*ACC_WIDTH-1:0]   matmul_i,
   input  logic                           ready_i,
   output logic                           valid_o,
   output logic [MAC_NUM*OUT_WIDTH-1:0]   data_o,
   output logic [$clog2(ROWS)-1:0]        row_idx_o,
   output logic                           frame_done_o,
   output logic                           overflow_o,
   output logic [15:0]                    sat_cnt_o
);

   localparam int RW = ACC_WIDTH + 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int IW = $clog2(ROWS);
   localparam int OW = MAC_NUM * OUT_WIDTH;
   localparam int CW = $clog2(MAC_NUM + 1);
   localparam logic signed [RW-1:0] SAT_HI = RW'((2 ** (OUT_WIDTH - 1)) - 1);
   localparam logic signed [RW-1:0] SAT_LO = ~SAT_HI;

   // stage 1 datapath
   logic signed [RW-1:0] rnd;
   logic signed [RW-1:0] sum    [MAC_NUM];
   logic signed [RW-1:0] r_next [MAC_NUM];
   logic signed [RW-1:0] s1_r   [MAC_NUM];
   logic                 s1_valid;

   // stage 2 / fifo
   logic signed [RW-1:0] lane;
   logic [CW-1:0]        sat_row;
   logic [OW-1:0]        pack_row;
   logic [16:0]          sat_sum;
   logic [OW-1:0]        mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [PW:0]          count;
   logic                 full;
   logic                 push;
   logic                 pop;
   logic                 drop;
   logic [IW-1:0]        row_idx;
   logic                 frame_done;
   logic                 overflow;
   logic [15:0]          sat_cnt;

   // rounding right shift, one guard bit so acc + half-LSB never wraps
   always_comb begin
      rnd = '0;
      if (shift_i != 5'd0)
         rnd = RW'(1) << (shift_i - 5'd1);
      for (int k = 0; k < MAC_NUM; k++) begin
         sum[k]    = $signed({matmul_i[k*ACC_WIDTH+ACC_WIDTH-1], matmul_i[k*ACC_WIDTH +: ACC_WIDTH]}) + rnd;
         r_next[k] = sum[k] >>> shift_i;
      end
   end

   // capture shifted lanes on the multiplier's done pulse
   always_ff @(posedge clk_i) begin
      if (done_i)
         s1_r <= r_next;
   end

   // saturate to int8, pack, count clamped lanes
   always_comb begin
      lane     = '0;
      sat_row  = '0;
      pack_row = '0;
      for (int k = 0; k < MAC_NUM; k++) begin
         lane = s1_r[k];
`ifdef MATMUL_REQUANT_RELU_EN
         if (lane[RW-1])
            lane = '0;
`endif
         if (lane > SAT_HI) begin
            lane    = SAT_HI;
            sat_row = sat_row + CW'(1);
         end else if (lane < SAT_LO) begin
            lane    = SAT_LO;
            sat_row = sat_row + CW'(1);
         end
         pack_row[k*OUT_WIDTH +: OUT_WIDTH] = lane[OUT_WIDTH-1:0];
      end
      sat_sum = {1'b0, sat_cnt} + 17'(sat_row);
   end

   assign full    = (count == (PW+1)'(FIFO_DEPTH));
   assign valid_o = (count != '0);
   assign pop     = valid_o & ready_i;
   assign push    = s1_valid & (~full | pop);
   assign drop    = s1_valid & full & ~pop;

   // row storage; pointers gate visibility so no reset is needed here
   always_ff @(posedge clk_i) begin
      if (push)
         mem[wr_ptr] <= pack_row;
   end

   // control: pipeline valid, fifo pointers, row/frame tracking, flags
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         s1_valid   <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         row_idx    <= '0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
         sat_cnt    <= '0;
      end else begin
         s1_valid   <= done_i;
         frame_done <= pop && (row_idx == IW'(ROWS - 1));
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
         if (drop)
            overflow <= 1'b1;
         if (s1_valid)
            sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
         if (pop)
            row_idx <= (row_idx == IW'(ROWS - 1)) ? '0 : row_idx + IW'(1);
      end
   end

   assign data_o       = valid_o ? mem[rd_ptr] : '0;
   assign row_idx_o    = row_idx;
   assign frame_done_o = frame_done;
   assign overflow_o   = overflow;
   assign sat_cnt_o    = sat_cnt;

endmodule

// File: tb/tb_matmul_requant_out.sv
// tb/tb_matmul_requant_out.sv - directed self-checking bench for matmul_requant_out
module tb_matmul_requant_out;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         clear = 1'b0;
   logic [4:0]   shift = '0;
   logic         done = 1'b0;
   logic [255:0] matmul = '0;
   logic         ready = 1'b0;
   logic         valid;
   logic [63:0]  data;
   logic [2:0]   row_idx;
   logic         frame_done;
   logic         overflow;
   logic [15:0]  sat_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   matmul_requant_out dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .clear_i      (clear),
      .shift_i      (shift),
      .done_i       (done),
      .matmul_i     (matmul),
      .ready_i      (ready),
      .valid_o      (valid),
      .data_o       (data),
      .row_idx_o    (row_idx),
      .frame_done_o (frame_done),
      .overflow_o   (overflow),
      .sat_cnt_o    (sat_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] mk(input int l0, input int l1, input int l2, input int l3, input int l4);
      logic [255:0] v;
      v = '0;
      v[31:0]    = l0;
      v[63:32]   = l1;
      v[95:64]   = l2;
      v[127:96]  = l3;
      v[159:128] = l4;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs_cnt;
      int fd_cnt;
      int fd_ok;
      int vis;
      logic last_hs;

      // reset
      step();
      step();
      rst = 1'b0;
      step();
      check("rst_valid", valid, 0);
      check("rst_data", data, 0);
      check("rst_row_idx", row_idx, 0);
      check("rst_overflow", overflow, 0);
      check("rst_sat_cnt", sat_cnt, 0);

      // rounding
      ready  = 1'b1;
      shift  = 5'd4;
      matmul = mk(256, 24, -24, 0, 0);
      done   = 1'b1;
      step();
      done = 1'b0;
      check("round_valid_n1", valid, 0);
      step();
      check("round_valid_n2", valid, 1);
`ifdef MATMUL_REQUANT_RELU_EN
      check("round_data", data, 64'h0000_0000_0000_0210);
`else
      check("round_data", data, 64'h0000_0000_00FF_0210);
`endif
      check("round_row_idx", row_idx, 0);
      check("round_sat_cnt", sat_cnt, 0);
      step();
      check("round_popped", valid, 0);
      check("round_row_adv", row_idx, 1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clear_row_idx", row_idx, 0);

      // saturation, two rows back to back
      shift  = 5'd0;
      matmul = mk(200, -300, 127, -128, 0);
      done   = 1'b1;
      step();
      matmul = mk(1000, -1000, 5, -5, 0);
      step();
      done = 1'b0;
`ifdef MATMUL_REQUANT_RELU_EN
      check("sat_data0", data, 64'h0000_0000_007F_007F);
      check("sat_cnt0", sat_cnt, 1);
`else
      check("sat_data0", data, 64'h0000_0000_807F_807F);
      check("sat_cnt0", sat_cnt, 2);
`endif
      step();
`ifdef MATMUL_REQUANT_RELU_EN
      check("sat_data1", data, 64'h0000_0000_0005_007F);
      check("sat_cnt1", sat_cnt, 2);
`else
      check("sat_data1", data, 64'h0000_0000_FB05_807F);
      check("sat_cnt1", sat_cnt, 4);
`endif
      step();
      check("sat_drained", valid, 0);
      clear = 1'b1;
      step();
      clear = 1'b0;

      // backpressure: 4 stored, 5th dropped
      ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         matmul = mk(i + 1, 0, 0, 0, 0);
         done   = 1'b1;
         step();
      end
      done = 1'b0;
      check("bp_no_ovf_yet", overflow, 0);
      step();
      check("bp_overflow", overflow, 1);
      check("bp_valid", valid, 1);
      step();
      ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("bp_drain_valid", valid, 1);
         check("bp_drain_data", data, 64'(i + 1));
         check("bp_drain_row", row_idx, 64'(i));
         step();
      end
      check("bp_empty", valid, 0);
      check("bp_ovf_sticky", overflow, 1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("bp_ovf_cleared", overflow, 0);

      // full frame of 8 rows
      hs_cnt = 0;
      fd_cnt = 0;
      fd_ok  = 0;
      for (int c = 0; c < 20; c++) begin
         done   = (c < 8);
         matmul = mk(c, 0, 0, 0, 0);
         last_hs = valid & ready & (hs_cnt == 7);
         if (valid & ready) begin
            check("frame_data", data, 64'(hs_cnt));
            hs_cnt++;
         end
         step();
         if (frame_done) begin
            fd_cnt++;
            if (last_hs)
               fd_ok++;
         end
      end
      done = 1'b0;
      check("frame_hs_cnt", 64'(hs_cnt), 8);
      check("frame_done_cnt", 64'(fd_cnt), 1);
      check("frame_done_timing", 64'(fd_ok), 1);
      check("frame_row_wrap", row_idx, 0);

      // clear mid-stream together with a done pulse
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         matmul = mk(8'h11 * (i + 1), 1000, 0, 0, 0);
         done   = 1'b1;
         step();
      end
      done = 1'b0;
      step();
      check("clr_pre_valid", valid, 1);
      check("clr_pre_sat", sat_cnt, 3);
      clear  = 1'b1;
      done   = 1'b1;
      matmul = mk(8'h44, 1000, 0, 0, 0);
      step();
      clear = 1'b0;
      done  = 1'b0;
      check("clr_valid", valid, 0);
      check("clr_overflow", overflow, 0);
      check("clr_sat_cnt", sat_cnt, 0);
      ready = 1'b1;
      vis = 0;
      for (int c = 0; c < 6; c++) begin
         if (valid)
            vis++;
         step();
      end
      check("clr_no_ghost_row", 64'(vis), 0);
      check("clr_sat_stays", sat_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/matmul_requant_out.md
Name: matmul_requant_out

Overview:
- Output stage directly downstream of the second matrix multiplier: consumes each 8-lane × 32-bit signed accumulator row on the multiplier's done pulse.
- Requantizes each lane to int8 with a rounding arithmetic right shift and saturation, then packs the row into 64 bits.
- Buffers packed rows in a small FIFO behind a valid/ready handshake for the writeback/DMA side.
- Tracks row position within a frame, sticky overflow and a saturation count.

Parameters:
- MAC_NUM, 8, lanes per row.
- ACC_WIDTH, 32, signed accumulator width per input lane.
- OUT_WIDTH, 8, signed output width per lane.
- FIFO_DEPTH, 4, packed rows buffered (power of two).
- ROWS, 8, rows per frame.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- clear_i  in  1  synchronous flush (pipeline, FIFO, counters, flags).
- shift_i  in  5  right-shift amount, sampled with done_i.
- done_i  in  1  single-cycle result-valid pulse from the multiplier.
- matmul_i  in  MAC_NUM*ACC_WIDTH  lane k at [32k+31:32k], signed.
- ready_i  in  1  downstream accepts data_o.
- valid_o  out  1  FIFO head valid.
- data_o  out  MAC_NUM*OUT_WIDTH  lane k at [8k+7:8k], signed int8.
- row_idx_o  out  $clog2(ROWS)  frame row index of the current data_o.
- frame_done_o  out  1  one-cycle pulse per completed frame.
- overflow_o  out  1  sticky, a row was dropped.
- sat_cnt_o  out  16  saturated-lane count, saturating at 0xFFFF.

Behaviour:
- Reset: clock is clk_i; reset is rst_i, synchronous, active-high. rst_i=1 forces valid_o=0, data_o=0, row_idx_o=0, frame_done_o=0, overflow_o=0, sat_cnt_o=0, and clears all pipeline valids and FIFO pointers. Reset asserted mid-operation discards everything in flight.
- clear_i: same effect as rst_i on all state and outputs. A done_i arriving in the same cycle as clear_i is discarded.
- Stage 1 (register on done_i): per lane, r = (acc + (shift ? 1<<(shift-1) : 0)) >>> shift, computed in ACC_WIDTH+1 bits so the rounding add cannot wrap.
- Stage 2: saturate r to [-128, 127], pack lanes, push to the FIFO. Count saturated lanes in the row (0..8) and add to sat_cnt_o, clamping at 0xFFFF.
- Pipeline never stalls. Latency: done_i at cycle N produces valid_o=1 at cycle N+2 when the FIFO was empty (first-word fall-through). Back-to-back done_i accepted every cycle.
- FIFO push when full:
  - If a pop (valid_o & ready_i) occurs the same cycle, the push succeeds.
  - Otherwise the row is dropped, overflow_o is set, and it holds until rst_i or clear_i.
- FIFO pop when empty: ignored.
- Handshake: data_o and row_idx_o hold stable while valid_o=1 and ready_i=0.
- Row counter advances on each pop and wraps from ROWS-1 to 0. frame_done_o pulses high in the cycle after the pop of row ROWS-1.
- Dropped rows do not advance the row counter.

Optional Feature:
- Macro: MATMUL_REQUANT_RELU_EN.
- Defined: lanes with negative r output 0 before saturation. Negative clamping is not counted in sat_cnt_o.
- Undefined: full signed int8 output, range [-128, 127].

Test Plan:
- Reset: hold rst_i 2 cycles, then release -> valid_o=0, data_o=0, row_idx_o=0, overflow_o=0, sat_cnt_o=0.
- Rounding: shift_i=4, lanes {256, 24, -24, 0,...}, ready_i=1 -> valid_o at done+2, lanes {0x10, 0x02, 0xFF, 0x00}, sat_cnt_o unchanged.
- Saturation: shift_i=0, lanes {200, -300, 127, -128, 0,...} -> {0x7F, 0x80, 0x7F, 0x80}, sat_cnt_o +2 per row.
- Backpressure: ready_i=0, 5 consecutive done_i pulses -> 4 rows stored, 5th dropped, overflow_o=1. Then ready_i=1 -> 4 rows drain in order with row_idx_o 0,1,2,3.
- Frame: 8 rows with ready_i=1 -> a single frame_done_o pulse one cycle after the 8th handshake; row_idx_o returns to 0.
- Clear mid-stream: FIFO holding 3 rows, then clear_i together with done_i -> next cycle valid_o=0, overflow_o=0, sat_cnt_o=0, and no row from that done_i ever appears.
